// File: rtl/pid_core_multi.sv
// ---------------------------------------------------------------------------
// pid_core_multi
//   Multi-channel second-order PID/IIR controller. One shared signed MAC unit
//   is time multiplexed over all channels; a sample strobe updates every
//   channel in ascending order:
//     y[n] = b0*e[n] + b1*e[n-1] + b2*e[n-2] - a1*y[n-1] - a0*y[n-2]
//   The y history holds the clamped outputs (anti-windup). A channel can be
//   put in manual mode, in which case its output and y history follow the
//   manual value while its e history keeps running (bumpless return).
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   sample_strb_i  one-cycle strobe that starts an update of all channels
//   adc_values_i   unsigned ADC values, ch k at [k*ADC_BITWIDTH +: ADC_BITWIDTH]
//   set_values_i   unsigned setpoints, same packing
//   coeffs_i       per channel {a0,a1,b2,b1,b0}, b0 in the lowest slice
//   manual_en_i    per channel manual mode enable
//   manual_vals_i  per channel signed manual output values
//   out_vals_o     per channel signed clamped outputs
//   sat_o          per channel: last result was clamped
//   busy_o         update sequence in progress (LOAD .. DONE)
//   done_strb_o    one-cycle pulse, all channels updated
//   overrun_strb_o one-cycle pulse, strobe arrived while busy
// ---------------------------------------------------------------------------
module pid_core_multi #(
  parameter int CHANNELS      = 2,
  parameter int ADC_BITWIDTH  = 8,
  parameter int REG_BITWIDTH  = 32,
  parameter int FRAC_BITWIDTH = 30,
  parameter int GUARD_BITS    = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 sample_strb_i,
  input  logic [CHANNELS*ADC_BITWIDTH-1:0]     adc_values_i,
  input  logic [CHANNELS*ADC_BITWIDTH-1:0]     set_values_i,
  input  logic [CHANNELS*5*REG_BITWIDTH-1:0]   coeffs_i,
  input  logic [CHANNELS-1:0]                  manual_en_i,
  input  logic [CHANNELS*(ADC_BITWIDTH+1)-1:0] manual_vals_i,
  output logic [CHANNELS*(ADC_BITWIDTH+1)-1:0] out_vals_o,
  output logic [CHANNELS-1:0]                  sat_o,
  output logic                                 busy_o,
  output logic                                 done_strb_o,
  output logic                                 overrun_strb_o
);

  localparam int DW = ADC_BITWIDTH + 1;        // signed error / output width
  localparam int PW = REG_BITWIDTH + DW;       // full product width
  localparam int AW = PW + GUARD_BITS;         // accumulator width
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic signed [AW-1:0] LIM = AW'((2 ** ADC_BITWIDTH) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Symmetric clamp to [-LIM, LIM].
  function automatic logic [DW-1:0] clamp_val_f(input logic signed [AW-1:0] v);
    if (v > LIM) begin
      return DW'(LIM);
    end else if (v < -LIM) begin
      return DW'(-LIM);
    end else begin
      return v[DW-1:0];
    end
  endfunction

  function automatic logic is_clamped_f(input logic signed [AW-1:0] v);
    return (v > LIM) || (v < -LIM);
  endfunction

  // Unpacked views of the packed input buses
  logic signed [REG_BITWIDTH-1:0] coef_s [CHANNELS][5];
  logic signed [DW-1:0]           err_s  [CHANNELS];
  logic signed [DW-1:0]           man_s  [CHANNELS];

  // State and datapath registers
  state_t                 state_q;
  logic                   accept_q;
  logic [CW-1:0]          ch_q;
  logic [2:0]             term_q;
  logic signed [AW-1:0]   acc_q;
  logic signed [DW-1:0]   e0_q  [CHANNELS];
  logic signed [DW-1:0]   e1_q  [CHANNELS];
  logic signed [DW-1:0]   e2_q  [CHANNELS];
  logic signed [DW-1:0]   y1_q  [CHANNELS];
  logic signed [DW-1:0]   y2_q  [CHANNELS];
  logic signed [DW-1:0]   out_q [CHANNELS];
  logic [CHANNELS-1:0]    sat_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   ovr_q;

  // Combinational datapath
  logic signed [REG_BITWIDTH-1:0] op_coef_s;
  logic signed [DW-1:0]           op_data_s;
  logic signed [PW-1:0]           prod_s;
  logic signed [AW-1:0]           acc_d;
  logic signed [AW-1:0]           res_s;
  logic signed [AW-1:0]           man_ext_s;
  logic signed [DW-1:0]           wr_val_s;
  logic                           wr_sat_s;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    for (genvar t = 0; t < 5; t++) begin : g_coef
      assign coef_s[k][t] = coeffs_i[(k*5+t)*REG_BITWIDTH +: REG_BITWIDTH];
    end
    assign err_s[k] = $signed({1'b0, set_values_i[k*ADC_BITWIDTH +: ADC_BITWIDTH]})
                    - $signed({1'b0, adc_values_i[k*ADC_BITWIDTH +: ADC_BITWIDTH]});
    assign man_s[k] = manual_vals_i[k*DW +: DW];
    assign out_vals_o[k*DW +: DW] = out_q[k];
  end

  // MAC operand select: term order b0,b1,b2,a1,a0; y terms enter negated
  always_comb begin
    op_coef_s = '0;
    op_data_s = '0;
    case (term_q)
      3'd0: begin op_coef_s = coef_s[ch_q][0]; op_data_s = e0_q[ch_q];  end
      3'd1: begin op_coef_s = coef_s[ch_q][1]; op_data_s = e1_q[ch_q];  end
      3'd2: begin op_coef_s = coef_s[ch_q][2]; op_data_s = e2_q[ch_q];  end
      3'd3: begin op_coef_s = coef_s[ch_q][3]; op_data_s = -y1_q[ch_q]; end
      3'd4: begin op_coef_s = coef_s[ch_q][4]; op_data_s = -y2_q[ch_q]; end
      default: begin op_coef_s = '0; op_data_s = '0; end
    endcase
  end

  // Product, accumulation (term 0 restarts the sum) and result/clamp selection
  always_comb begin
    prod_s    = $signed({{DW{op_coef_s[REG_BITWIDTH-1]}}, op_coef_s})
              * $signed({{REG_BITWIDTH{op_data_s[DW-1]}}, op_data_s});
    acc_d     = ((term_q == 3'd0) ? '0 : acc_q) + {{GUARD_BITS{prod_s[PW-1]}}, prod_s};
    res_s     = acc_q >>> FRAC_BITWIDTH;
    man_ext_s = {{(AW-DW){man_s[ch_q][DW-1]}}, man_s[ch_q]};
    if (manual_en_i[ch_q]) begin
      wr_val_s = clamp_val_f(man_ext_s);
      wr_sat_s = 1'b0;
    end else begin
      wr_val_s = clamp_val_f(res_s);
      wr_sat_s = is_clamped_f(res_s);
    end
  end

  // Sequencer FSM together with all history and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      accept_q <= 1'b0;
      ch_q     <= '0;
      term_q   <= 3'd0;
      acc_q    <= '0;
      sat_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        e0_q[k]  <= '0;
        e1_q[k]  <= '0;
        e2_q[k]  <= '0;
        y1_q[k]  <= '0;
        y2_q[k]  <= '0;
        out_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      // A strobe is taken once, in IDLE; any strobe while a sequence is
      // pending or running only raises the overrun pulse.
      accept_q <= sample_strb_i && (state_q == S_IDLE) && !accept_q;
      ovr_q    <= sample_strb_i && ((state_q != S_IDLE) || accept_q);
      case (state_q)
        S_IDLE: begin
          if (accept_q) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          for (int k = 0; k < CHANNELS; k++) begin
            e0_q[k] <= err_s[k];
            e1_q[k] <= e0_q[k];
            e2_q[k] <= e1_q[k];
          end
          ch_q    <= '0;
          term_q  <= 3'd0;
          state_q <= S_MAC;
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (term_q == 3'd4) begin
            term_q  <= 3'd0;
            state_q <= S_WRITE;
          end else begin
            term_q <= term_q + 3'd1;
          end
        end
        S_WRITE: begin
          out_q[ch_q] <= wr_val_s;
          sat_q[ch_q] <= wr_sat_s;
          y2_q[ch_q]  <= y1_q[ch_q];
          y1_q[ch_q]  <= wr_val_s;
          if (ch_q == CW'(CHANNELS - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            ch_q    <= ch_q + CW'(1);
            state_q <= S_MAC;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sat_o          = sat_q;
  assign busy_o         = busy_q;
  assign done_strb_o    = done_q;
  assign overrun_strb_o = ovr_q;

endmodule
